// File: rtl/msx_slot_config_ctrl.sv
// N-slot cartridge configuration decoder with debounced reload-request handshake.
// Optional ack timeout in REQ is enabled by defining RELOAD_TIMEOUT_EN.
module msx_slot_config_ctrl #(
    parameter int unsigned SLOTS          = 2,
    parameter logic [2:0]  TYP_LIMIT      = 3'd5,
    parameter logic [2:0]  TYP_EMPTY      = 3'd7,
    parameter logic [2:0]  TYP_ROM        = 3'd0,
    parameter logic [3:0]  MAPPER_OFS     = 4'd2,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SLOTS*10-1:0]   cfg_raw,
    output logic [SLOTS*3-1:0]    cart_typ,
    output logic [SLOTS*4-1:0]    cart_mapper,
    output logic [SLOTS*3-1:0]    cart_sram,
    output logic [SLOTS-1:0]      rom_load_hide,
    output logic [SLOTS-1:0]      sram_hide,
    output logic                  reload,
    input  logic                  reload_ack,
    output logic [SLOTS-1:0]      dirty_mask,
    output logic                  reload_timeout
);

    localparam int unsigned MaxCyc = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                     : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCyc) + 1;
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
`ifdef RELOAD_TIMEOUT_EN
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {StIdle, StSettle, StReq} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [SLOTS*10-1:0]   snap_q, snap_d;
    logic [SLOTS*10-1:0]   cand_q, cand_d;
    logic                  reload_q, reload_d;
    logic [SLOTS-1:0]      dirty_q, dirty_d;
    logic [SLOTS*10-1:0]   dec_cfg;
    logic [SLOTS-1:0]      slot_diff;

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        logic [2:0] typ_raw, typ_dec, sram_raw, sram_dec;
        logic [3:0] map_raw, map_dec;
        logic       rom_hide, s_hide;

        assign typ_raw  = cfg_raw[10*s +: 3];
        assign map_raw  = cfg_raw[10*s+3 +: 4];
        assign sram_raw = cfg_raw[10*s+7 +: 3];
        assign typ_dec  = (typ_raw < TYP_LIMIT) ? typ_raw : TYP_EMPTY;
        assign map_dec  = map_raw + MAPPER_OFS;
        assign rom_hide = (typ_dec != TYP_ROM);
        assign s_hide   = rom_hide | (map_raw == 4'd0);
        assign sram_dec = s_hide ? 3'd0 : sram_raw;

        assign cart_typ[3*s +: 3]    = typ_dec;
        assign cart_mapper[4*s +: 4] = map_dec;
        assign cart_sram[3*s +: 3]   = sram_dec;
        assign rom_load_hide[s]      = rom_hide;
        assign sram_hide[s]          = s_hide;
        assign dec_cfg[10*s +: 10]   = {typ_dec, map_dec, sram_dec};
        assign slot_diff[s]          = (cand_q[10*s +: 10] != snap_q[10*s +: 10]);
    end

`ifdef RELOAD_TIMEOUT_EN
    logic tmo_q, tmo_d;
    assign reload_timeout = tmo_q;
`else
    assign reload_timeout = 1'b0;
`endif

    assign reload     = reload_q;
    assign dirty_mask = dirty_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        cand_d   = cand_q;
        reload_d = reload_q;
        dirty_d  = dirty_q;
`ifdef RELOAD_TIMEOUT_EN
        tmo_d    = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (dec_cfg != snap_q) begin
                    state_d = StSettle;
                    cand_d  = dec_cfg;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (dec_cfg == snap_q) begin
                    state_d = StIdle;
                end else if (dec_cfg != cand_q) begin
                    cand_d = dec_cfg;
                    cnt_d  = '0;
                end else if (cnt_q == SettleLast) begin
                    state_d  = StReq;
                    reload_d = 1'b1;
                    dirty_d  = slot_diff;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReq: begin
                // Candidate is frozen here; input changes are picked up again from IDLE.
                if (reload_ack) begin
                    snap_d   = cand_q;
                    reload_d = 1'b0;
                    dirty_d  = '0;
                    state_d  = StIdle;
                end
`ifdef RELOAD_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    snap_d   = cand_q;
                    reload_d = 1'b0;
                    dirty_d  = '0;
                    tmo_d    = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            snap_q   <= dec_cfg;
            cand_q   <= dec_cfg;
            reload_q <= 1'b0;
            dirty_q  <= '0;
`ifdef RELOAD_TIMEOUT_EN
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            cand_q   <= cand_d;
            reload_q <= reload_d;
            dirty_q  <= dirty_d;
`ifdef RELOAD_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_msx_slot_config_ctrl.sv
// Bench for msx_slot_config_ctrl: directed scenarios plus random traffic checked against a
// run-length model of the debounce/handshake behaviour.
module tb_msx_slot_config_ctrl;

    localparam int SLOTS = 2;
    localparam int SETTLE = 4;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] cfg_raw = '0;
    logic        reload_ack = 1'b0;
    logic [5:0]  cart_typ, cart_sram;
    logic [7:0]  cart_mapper;
    logic [1:0]  rom_load_hide, sram_hide, dirty_mask;
    logic        reload, reload_timeout;

    msx_slot_config_ctrl #(
        .SLOTS(SLOTS), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .cfg_raw(cfg_raw), .cart_typ(cart_typ),
        .cart_mapper(cart_mapper), .cart_sram(cart_sram), .rom_load_hide(rom_load_hide),
        .sram_hide(sram_hide), .reload(reload), .reload_ack(reload_ack),
        .dirty_mask(dirty_mask), .reload_timeout(reload_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: a request fires once the decoded config has read the same, non-snapshot value on
    // SETTLE+1 consecutive sampling edges outside a request.
    logic [19:0] m_snap, m_last, m_cand;
    int          m_run, m_wait;
    bit          m_req, m_tmo;
    logic [1:0]  m_mask;

    function automatic logic [11:0] ref_slot(input logic [9:0] raw);
        int t, m, sr, td, md, sd;
        bit rh, sh;
        t  = int'(raw[2:0]);
        m  = int'(raw[6:3]);
        sr = int'(raw[9:7]);
        td = (t >= 5) ? 7 : t;
        md = (m + 2) % 16;
        rh = (td != 0);
        sh = rh || (m == 0);
        sd = sh ? 0 : sr;
        return {rh, sh, 3'(td), 4'(md), 3'(sd)};
    endfunction

    function automatic logic [19:0] dec_all(input logic [19:0] raw);
        logic [19:0] r;
        for (int s = 0; s < SLOTS; s++) r[10*s +: 10] = ref_slot(raw[10*s +: 10])[9:0];
        return r;
    endfunction

    function automatic logic [9:0] pk(input int sram, input int mapper, input int typ);
        return {3'(sram), 4'(mapper), 3'(typ)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [19:0] cur;
        cur = dec_all(cfg_raw);
        m_tmo = 0;
        if (reset) begin
            m_snap = cur; m_req = 0; m_run = 0; m_mask = '0;
        end else if (m_req) begin
            if (reload_ack) begin
                m_snap = m_cand; m_req = 0; m_run = 0;
            end
`ifdef RELOAD_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_snap = m_cand; m_req = 0; m_run = 0; m_tmo = 1;
                end
            end
`endif
        end else if (cur == m_snap) begin
            m_run = 0;
        end else begin
            m_run  = (m_run > 0 && cur == m_last) ? m_run + 1 : 1;
            m_last = cur;
            if (m_run == SETTLE + 1) begin
                m_req = 1; m_cand = cur; m_wait = 0;
                for (int s = 0; s < SLOTS; s++)
                    m_mask[s] = (cur[10*s +: 10] != m_snap[10*s +: 10]);
            end
        end
    endtask

    task automatic check_all();
        logic [11:0] e;
        chk("reload", 32'(reload), 32'(m_req));
        chk("dirty_mask", 32'(dirty_mask), m_req ? 32'(m_mask) : 32'd0);
        chk("reload_timeout", 32'(reload_timeout), 32'(m_tmo));
        for (int s = 0; s < SLOTS; s++) begin
            e = ref_slot(cfg_raw[10*s +: 10]);
            chk("cart_typ", 32'(cart_typ[3*s +: 3]), 32'(e[9:7]));
            chk("cart_mapper", 32'(cart_mapper[4*s +: 4]), 32'(e[6:3]));
            chk("cart_sram", 32'(cart_sram[3*s +: 3]), 32'(e[2:0]));
            chk("rom_load_hide", 32'(rom_load_hide[s]), 32'(e[11]));
            chk("sram_hide", 32'(sram_hide[s]), 32'(e[10]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Ticks until reload rises; returns the number of edges taken (0 when the bound expires).
    task automatic wait_reload(input int bound, output int n);
        n = 0;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (reload) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic ack_once();
        reload_ack = 1'b1;
        tick();
        reload_ack = 1'b0;
        chk("reload_after_ack", 32'(reload), 32'd0);
    endtask

    initial begin
        int n, since, seen;
        logic [9:0] s0, s1;

        // 1: reset with slot0 ROM, mapper 1
        s0 = pk(3, 1, 0);
        s1 = pk(2, 4, 3);
        cfg_raw = {s1, s0};
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("t1_reload", 32'(reload), 32'd0);
        chk("t1_mapper0", 32'(cart_mapper[3:0]), 32'd3);
        chk("t1_rom_hide", 32'(rom_load_hide), 32'b10);

        // 2: slot1 type changes and is held
        s1 = pk(2, 4, 0);
        cfg_raw = {s1, s0};
        wait_reload(20, n);
        chk("t2a_latency", 32'(n), 32'(SETTLE + 1));
        ack_once();
        s1 = pk(2, 4, 1);
        cfg_raw = {s1, s0};
        wait_reload(20, n);
        chk("t2_latency", 32'(n), 32'(SETTLE + 1));
        chk("t2_dirty", 32'(dirty_mask), 32'b10);
        ack_once();

        // 3: slot0 mapper toggles every 2 cycles, then settles
        for (int i = 0; i < 10; i++) begin
            s0 = pk(3, (i % 2 == 0) ? 5 : 6, 0);
            cfg_raw = {s1, s0};
            tick();
            tick();
            chk("t3_no_reload", 32'(reload), 32'd0);
        end
        since = 2;
        wait_reload(20, n);
        chk("t3_latency", 32'(since + n), 32'(SETTLE + 1));
        chk("t3_dirty", 32'(dirty_mask), 32'b01);
        ack_once();

        // 4: change then revert within 3 cycles
        cfg_raw = {s1, pk(1, 9, 2)};
        seen = 0;
        for (int i = 0; i < 3; i++) begin tick(); seen |= int'(reload); end
        cfg_raw = {s1, s0};
        for (int i = 0; i < 12; i++) begin tick(); seen |= int'(reload); end
        chk("t4_never", 32'(seen), 32'd0);

        // 5: out-of-range type and mapper wrap
        s0 = pk(5, 15, 6);
        cfg_raw = {s1, s0};
        #1;
        chk("t5_typ", 32'(cart_typ[2:0]), 32'd7);
        chk("t5_sram_hide", 32'(sram_hide[0]), 32'd1);
        chk("t5_sram", 32'(cart_sram[2:0]), 32'd0);
        chk("t5_mapper", 32'(cart_mapper[3:0]), 32'd1);
        wait_reload(20, n);
        chk("t5_latency", 32'(n), 32'(SETTLE + 1));
        ack_once();

        // 6: reset while a request is pending
        s0 = pk(2, 3, 0);
        cfg_raw = {s1, s0};
        wait_reload(20, n);
        chk("t6_req", 32'(reload), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_reset_reload", 32'(reload), 32'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin tick(); seen |= int'(reload); end
        chk("t6_no_rerequest", 32'(seen), 32'd0);
`ifdef RELOAD_TIMEOUT_EN
        cfg_raw = {pk(0, 7, 1), s0};
        wait_reload(20, n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (reload_timeout) begin n = i; break; end
        end
        chk("t6_timeout_cycles", 32'(n), 32'(TMO));
        chk("t6_timeout_reload", 32'(reload), 32'd0);
`endif

        // Random traffic: sticky configs, occasional ack and reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) cfg_raw = 20'($urandom);
            else if ($urandom_range(0, 9) == 0) cfg_raw[10*$urandom_range(0, 1) +: 3] =
                3'($urandom);
            reload_ack = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 79) == 0);
            tick();
        end
        reset = 1'b0;
        reload_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
